conv_window_sched: RTL and testbench
====================================

CONV_WINDOW_SCHED -- requirements
Module: conv_window_sched

Interface
REQ-001 Parameter LAT, default 6: fixed issue-to-result latency of the convolution datapath (multiply stage plus five adder stages).
REQ-002 Parameter CREDITS, default 8: depth of the downstream result buffer; maximum windows issued but not yet popped.
REQ-003 Ports, one per line: name direction width meaning.
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a frame; sampled only in IDLE.
- filter_size  input  1  0 = 3x3, 1 = 5x5; captured with start.
- image_size  input  4  side length N; legal range 4..8; captured with start.
- img_ready  input  1  image buffer fully loaded and padded.
- abort  input  1  cancel the current frame.
- res_pop  input  1  downstream consumed one result from the result buffer.
- win_valid  output  1  window issue strobe to the datapath.
- win_row  output  3  output row index of the issued window.
- win_col  output  3  output column index of the issued window.
- win_last  output  1  the issued window is the frame's final window (N*N-1).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the frame completes.
- cfg_err  output  1  one-cycle pulse when start carries an illegal image_size.
- flush_req  output  1  one-cycle pulse requesting datapath and buffer flush on abort.

Function
REQ-004 States: IDLE, WAIT_IMG, ISSUE, DRAIN. All transitions are registered.
REQ-005 IDLE: start with 4<=image_size<=8 -> capture image_size and filter_size, load credit=CREDITS, clear counters -> WAIT_IMG. Start with an illegal image_size -> cfg_err pulse on the next cycle, remain IDLE, keep the previous configuration.
REQ-006 WAIT_IMG: img_ready high -> ISSUE on the next cycle. No window issues in WAIT_IMG.
REQ-007 ISSUE: win_valid is asserted in a cycle iff credit>0. When issued, it carries the current (row, col). col increments; after N-1, col wraps to 0 and row increments (row-major order).
REQ-008 win_row, win_col and win_last are registered and valid only while win_valid=1; they are held at 0 otherwise.
REQ-009 The datapath applies the filter_size centring offset; the scheduler issues output coordinates only and issues exactly N*N windows for both filter sizes.
REQ-010 When the window with win_last=1 issues -> DRAIN on the next cycle.
REQ-011 Credit accounting: an issue alone decrements credit; res_pop alone increments it; an issue and a pop in the same cycle leave it unchanged. Credit never exceeds CREDITS; res_pop at credit=CREDITS is ignored.
REQ-012 popped_cnt counts res_pop in WAIT_IMG, ISSUE and DRAIN, width 7 (max 64).
REQ-013 DRAIN: when popped_cnt reaches N*N -> done pulse for one cycle and return to IDLE in the same transition.
REQ-014 abort in WAIT_IMG, ISSUE or DRAIN takes priority over every other event: win_valid=0 in the following cycle, one flush_req pulse, return to IDLE, no done pulse. abort in IDLE is ignored.
REQ-015 start outside IDLE is ignored.
REQ-016 A throughput-limited frame completes no earlier than N*N + LAT cycles after entering ISSUE. With res_pop tied high one cycle after each result, the issue rate is one window per cycle.

Reset
REQ-017 rst forces IDLE in the next cycle. All outputs are 0 and all counters are 0; credit is 0 until the next start.
REQ-018 rst overrides start, abort and res_pop in the same cycle. rst mid-frame produces no done and no flush_req pulse.

Verification
REQ-019 N=4, filter 3x3, img_ready after 3 cycles, res_pop LAT cycles after each issue -> 16 consecutive issues (0,0)..(3,3), win_last on (3,3), one done pulse, busy falls with done.
REQ-020 N=8, filter 5x5, res_pop never asserted -> exactly 8 issues, then win_valid stays low. Enabling res_pop resumes issue at (1,0).
REQ-021 image_size=3 and then image_size=9 with start -> a cfg_err pulse for each, busy stays 0, no issues.
REQ-022 N=5: abort on the 10th issue cycle -> win_valid=0 the next cycle, one flush_req pulse, IDLE. A following legal start restarts at (0,0).
REQ-023 Credit at 0, with a simultaneous res_pop and ISSUE-state cycle -> credit becomes 1 and the issue occurs in the next cycle. In a cycle with both an issue and a pop, credit is unchanged.
REQ-024 rst asserted in the middle of DRAIN -> IDLE, all outputs 0, no done pulse. start is ignored while busy.

Source files
------------

// File: rtl/conv_window_sched.sv
// Window issue scheduler for the convolution datapath: walks the N x N output
// grid in row-major order under a credit limit set by the result buffer depth.
//
// state    | meaning
// IDLE     | waiting for a legal start
// WAIT_IMG | frame configured, waiting for the image buffer
// ISSUE    | issuing windows while credit allows
// DRAIN    | all windows issued, waiting for the remaining results
module conv_window_sched #(
  parameter int LAT     = 6,
  parameter int CREDITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       filter_size,
  input  logic [3:0] image_size,
  input  logic       img_ready,
  input  logic       abort,
  input  logic       res_pop,
  output logic       win_valid,
  output logic [2:0] win_row,
  output logic [2:0] win_col,
  output logic       win_last,
  output logic       busy,
  output logic       done,
  output logic       cfg_err,
  output logic       flush_req
);

  localparam int CW = $clog2(CREDITS + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IMG = 2'd1,
    ISSUE    = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    n_q, n_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [2:0]    row_q, row_d;
  logic [2:0]    col_q, col_d;
  logic [6:0]    popped_q, popped_d;
  logic [7:0]    drain_tmr_q, drain_tmr_d;
  logic          win_valid_q, win_valid_d;
  logic [2:0]    win_row_q, win_row_d;
  logic [2:0]    win_col_q, win_col_d;
  logic          win_last_q, win_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;
  logic          flush_q, flush_d;

  logic          issue;
  logic          pop_ok;
  logic          size_legal;
  logic [2:0]    nm1_q;
  logic [2:0]    nm1_d;
  logic [6:0]    n_sq;

  // The centring offset for filter_size is applied by the datapath; the
  // captured value is kept only so the frame configuration is complete.
  logic          filt_unused;
  assign filt_unused = filt_q;

  assign issue      = win_valid_q;
  assign size_legal = (image_size >= 4'd4) && (image_size <= 4'd8);
  assign nm1_q      = 3'(n_q - 4'd1);
  assign nm1_d      = 3'(n_d - 4'd1);
  assign n_sq       = 7'(n_q) * 7'(n_q);
  // A pop at full credit is dropped unless an issue consumes a slot that cycle.
  assign pop_ok     = res_pop && (state_q != IDLE) &&
                      (issue || (credit_q < CW'(CREDITS)));

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    filt_d      = filt_q;
    credit_d    = credit_q;
    row_d       = row_q;
    col_d       = col_q;
    popped_d    = popped_q;
    drain_tmr_d = drain_tmr_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    flush_d     = 1'b0;

    if (state_q != IDLE && res_pop && popped_q != 7'h7F) begin
      popped_d = popped_q + 7'd1;
    end

    if (issue && !pop_ok) begin
      credit_d = credit_q - CW'(1);
    end else if (!issue && pop_ok) begin
      credit_d = credit_q + CW'(1);
    end

    if (issue) begin
      if (col_q == nm1_q) begin
        col_d = 3'd0;
        row_d = row_q + 3'd1;
      end else begin
        col_d = col_q + 3'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (size_legal) begin
            state_d  = WAIT_IMG;
            n_d      = image_size;
            filt_d   = filter_size;
            credit_d = CW'(CREDITS);
            row_d    = 3'd0;
            col_d    = 3'd0;
            popped_d = 7'd0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      WAIT_IMG: begin
        if (img_ready) state_d = ISSUE;
      end
      ISSUE: begin
        if (issue && win_last_q) begin
          state_d     = DRAIN;
          drain_tmr_d = 8'(LAT);
        end
      end
      DRAIN: begin
        // The timer keeps completion no earlier than the datapath latency.
        if (drain_tmr_q != 8'd0) drain_tmr_d = drain_tmr_q - 8'd1;
        if (popped_q >= n_sq && drain_tmr_q == 8'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      flush_d = 1'b1;
      done_d  = 1'b0;
    end

    if (state_d == IDLE && state_q != IDLE) begin
      credit_d    = '0;
      row_d       = 3'd0;
      col_d       = 3'd0;
      popped_d    = 7'd0;
      drain_tmr_d = 8'd0;
    end

    win_valid_d = (state_d == ISSUE) && (credit_d != '0);
    win_row_d   = win_valid_d ? row_d : 3'd0;
    win_col_d   = win_valid_d ? col_d : 3'd0;
    win_last_d  = win_valid_d && (row_d == nm1_d) && (col_d == nm1_d);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= 4'd0;
      filt_q      <= 1'b0;
      credit_q    <= '0;
      row_q       <= 3'd0;
      col_q       <= 3'd0;
      popped_q    <= 7'd0;
      drain_tmr_q <= 8'd0;
      win_valid_q <= 1'b0;
      win_row_q   <= 3'd0;
      win_col_q   <= 3'd0;
      win_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      filt_q      <= filt_d;
      credit_q    <= credit_d;
      row_q       <= row_d;
      col_q       <= col_d;
      popped_q    <= popped_d;
      drain_tmr_q <= drain_tmr_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_last_q  <= win_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      flush_q     <= flush_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign win_last  = win_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign flush_req = flush_q;

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched: a start-vector table plus hand-written
// frame sequences for credit stall, abort, and reset during drain.
module tb_conv_window_sched;

  localparam int LAT     = 6;
  localparam int CREDITS = 8;

  logic       clk = 1'b0;
  logic       rst, start, filter_size, img_ready, abort, res_pop;
  logic [3:0] image_size;
  logic       win_valid, win_last, busy, done, cfg_err, flush_req;
  logic [2:0] win_row, win_col;

  int checks = 0;
  int errors = 0;

  conv_window_sched #(.LAT(LAT), .CREDITS(CREDITS)) dut (
    .clk(clk), .rst(rst), .start(start), .filter_size(filter_size),
    .image_size(image_size), .img_ready(img_ready), .abort(abort),
    .res_pop(res_pop), .win_valid(win_valid), .win_row(win_row),
    .win_col(win_col), .win_last(win_last), .busy(busy), .done(done),
    .cfg_err(cfg_err), .flush_req(flush_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] size;
    logic       filt;
    logic       exp_err;
    logic       exp_busy;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, int'(win_valid), 0);
    chk({tag, "_row"}, int'(win_row), 0);
    chk({tag, "_col"}, int'(win_col), 0);
    chk({tag, "_last"}, int'(win_last), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
    chk({tag, "_flush"}, int'(flush_req), 0);
  endtask

  task automatic do_start(input int n, input logic f);
    start = 1'b1;
    image_size = 4'(n);
    filter_size = f;
    tick();
    start = 1'b0;
  endtask

  // Runs a frame with results popped LAT cycles after each issue; optionally
  // asserts rst rst_after cycles after the last issue.
  task automatic run_frame(input int n, input int rst_after, output int n_iss,
                           output int n_done, output int first_c, output int done_c);
    logic pop_at [0:511];
    int   k, last_c;
    logic prev_busy;
    for (int i = 0; i < 512; i++) pop_at[i] = 1'b0;
    k = 0; n_done = 0; first_c = -1; done_c = -1; last_c = -1;
    prev_busy = busy;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (win_valid) begin
        if (k == 0) first_c = cyc;
        chk("frame_row", int'(win_row), k / n);
        chk("frame_col", int'(win_col), k % n);
        chk("frame_last", int'(win_last), int'(k == n * n - 1));
        chk("frame_consecutive", cyc, first_c + k);
        pop_at[cyc + LAT] = 1'b1;
        if (win_last) last_c = cyc;
        k++;
      end
      if (done) begin
        n_done++;
        done_c = cyc;
        chk("busy_falls_with_done", int'(busy), 0);
        chk("busy_before_done", int'(prev_busy), 1);
      end
      prev_busy = busy;
      res_pop = pop_at[cyc];
      if (rst_after >= 0 && last_c >= 0 && cyc == last_c + rst_after) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        res_pop = 1'b0;
        break;
      end
      if (n_done > 0 && cyc > done_c + 2) break;
      tick();
    end
    res_pop = 1'b0;
    n_iss = k;
  endtask

  initial begin
    vec_t tbl [9];
    int   n_iss, n_done, first_c, done_c, k, lr, lc, seen;

    tbl[0] = '{4'd3,  1'b0, 1'b1, 1'b0};
    tbl[1] = '{4'd9,  1'b1, 1'b1, 1'b0};
    tbl[2] = '{4'd0,  1'b0, 1'b1, 1'b0};
    tbl[3] = '{4'd15, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{4'd4,  1'b0, 1'b0, 1'b1};
    tbl[5] = '{4'd8,  1'b1, 1'b0, 1'b1};
    tbl[6] = '{4'd5,  1'b0, 1'b0, 1'b1};
    tbl[7] = '{4'd6,  1'b1, 1'b0, 1'b1};
    tbl[8] = '{4'd7,  1'b0, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; filter_size = 1'b0; image_size = 4'd0;
    img_ready = 1'b0; abort = 1'b0; res_pop = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_idle("reset");
    res_pop = 1'b1;
    tick();
    res_pop = 1'b0;
    chk_idle("idle_pop");

    // Start-vector table: illegal sizes pulse cfg_err; legal ones go busy and are aborted.
    for (int i = 0; i < 9; i++) begin
      do_start(int'(tbl[i].size), tbl[i].filt);
      chk("tbl_cfg_err", int'(cfg_err), int'(tbl[i].exp_err));
      chk("tbl_busy", int'(busy), int'(tbl[i].exp_busy));
      chk("tbl_no_issue", int'(win_valid), 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("tbl_flush", int'(flush_req), int'(tbl[i].exp_busy));
      chk("tbl_busy_after_abort", int'(busy), 0);
      chk("tbl_cfg_err_pulse", int'(cfg_err), 0);
    end

    // N=4, 3x3, image ready after 3 cycles, pops LAT after issue; start ignored while busy.
    do_start(4, 1'b0);
    img_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("wait_img_no_issue", int'(win_valid), 0);
      start = (c == 1);
      image_size = 4'd3;
      tick();
      start = 1'b0;
      if (c == 1) chk("start_ignored_busy", int'(cfg_err), 0);
    end
    img_ready = 1'b1;
    run_frame(4, -1, n_iss, n_done, first_c, done_c);
    chk("n4_issues", n_iss, 16);
    chk("n4_dones", n_done, 1);
    chk("n4_min_latency", int'((done_c - first_c) >= 16 + LAT), 1);
    chk_idle("n4_end");

    // N=8, 5x5 with no pops: credit limits issue to 8, then a pop resumes at (1,0).
    do_start(8, 1'b1);
    seen = 0; lr = -1; lc = -1;
    for (int c = 0; c < 40; c++) begin
      if (win_valid) begin
        seen++;
        lr = int'(win_row);
        lc = int'(win_col);
      end
      tick();
    end
    chk("n8_stall_issues", seen, 8);
    chk("n8_stall_row", lr, 0);
    chk("n8_stall_col", lc, 7);
    chk("n8_stalled", int'(win_valid), 0);
    res_pop = 1'b1;
    tick();
    chk("resume_valid", int'(win_valid), 1);
    chk("resume_row", int'(win_row), 1);
    chk("resume_col", int'(win_col), 0);
    tick();
    res_pop = 1'b0;
    chk("issue_pop_valid", int'(win_valid), 1);
    chk("issue_pop_col", int'(win_col), 1);
    tick();
    chk("credit_empty_again", int'(win_valid), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("n8_flush", int'(flush_req), 1);
    chk("n8_idle_busy", int'(busy), 0);

    // N=5: abort on the 10th issue cycle, then restart from (0,0).
    res_pop = 1'b1;
    do_start(5, 1'b0);
    k = 0;
    for (int c = 0; c < 60; c++) begin
      if (win_valid) begin
        chk("n5_row", int'(win_row), k / 5);
        chk("n5_col", int'(win_col), k % 5);
        k++;
        if (k == 10) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          res_pop = 1'b0;
          chk("abort_valid", int'(win_valid), 0);
          chk("abort_flush", int'(flush_req), 1);
          chk("abort_busy", int'(busy), 0);
          chk("abort_no_done", int'(done), 0);
          tick();
          chk("abort_flush_pulse", int'(flush_req), 0);
          break;
        end
      end
      tick();
    end
    chk("abort_reached", k, 10);
    do_start(5, 1'b0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (win_valid) begin
        seen = 1;
        chk("restart_row", int'(win_row), 0);
        chk("restart_col", int'(win_col), 0);
        break;
      end
      tick();
    end
    chk("restart_issued", seen, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // N=4 with rst two cycles into DRAIN.
    do_start(4, 1'b0);
    run_frame(4, 2, n_iss, n_done, first_c, done_c);
    chk("rst_drain_issues", n_iss, 16);
    chk("rst_drain_no_done", n_done, 0);
    chk_idle("rst_drain");
    for (int c = 0; c < 8; c++) begin
      res_pop = 1'b1;
      tick();
      if (done || flush_req || busy || win_valid) begin
        chk("post_rst_quiet", 1, 0);
      end
    end
    res_pop = 1'b0;
    chk_idle("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
